// File: rtl/pc_control_if.sv
// Fetch-side bus between the PC sequencer and its surroundings (decode, regfile, decision unit).
interface pc_control_if #(
    parameter int unsigned CNT_W = 16
);
    logic [15:0]      instr;
    logic [15:0]      rs_data;
    logic             stall_en;
    logic             take_branch;
    logic             freeze;
    logic [15:0]      pc;
    logic [15:0]      pc_plus2;
    logic             has_stalled;
    logic             halted;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output instr, rs_data, stall_en, take_branch, freeze,
        input  pc, pc_plus2, has_stalled, halted, taken_cnt
    );

    modport slave (
        input  instr, rs_data, stall_en, take_branch, freeze,
        output pc, pc_plus2, has_stalled, halted, taken_cnt
    );
endinterface

// File: rtl/pc_control.sv
// Program counter and branch-stall sequencer: 1 instr/cycle, every B/BR spends one resolve cycle.
module pc_control #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned CNT_W    = 16
) (
    input logic        clk,
    input logic        rst,
    pc_control_if.slave bus
);
    localparam int unsigned PC_W = 16;
    localparam logic [3:0] OP_B   = 4'hC;
    localparam logic [3:0] OP_BR  = 4'hD;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {RUN, BR_WAIT, HALT} state_t;

    state_t           state, state_n;
    logic [PC_W-1:0]  pc_q, pc_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             has_stalled_q, halted_q;

    logic [3:0]       opcode;
    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  b_off;
    logic [CNT_W-1:0] cnt_inc;
    logic             unused_instr_bits;

    assign opcode            = bus.instr[15:12];
    assign pc_inc            = pc_q + PC_W'(2);
    assign b_off             = {{6{bus.instr[8]}}, bus.instr[8:0], 1'b0};
    assign cnt_inc           = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    assign unused_instr_bits = ^{bus.instr[11:9], bus.rs_data[0]};

    // State, PC and counter registers; status flags track the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= RUN;
            pc_q          <= RESET_PC;
            cnt_q         <= '0;
            has_stalled_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state         <= state_n;
            pc_q          <= pc_n;
            cnt_q         <= cnt_n;
            has_stalled_q <= (state_n == BR_WAIT);
            halted_q      <= (state_n == HALT);
        end
    end

    // Next-state / next-PC selection; freeze leaves all defaults (hold) in place.
    always_comb begin
        state_n = state;
        pc_n    = pc_q;
        cnt_n   = cnt_q;
        if (!bus.freeze) begin
            unique case (state)
                RUN: begin
                    if (opcode == OP_HLT) begin
                        state_n = HALT;
                    end else if (bus.stall_en) begin
                        state_n = BR_WAIT;
                    end else begin
                        pc_n = pc_inc;
                    end
                end
                BR_WAIT: begin
                    state_n = RUN;
                    if (bus.take_branch && opcode == OP_B) begin
                        pc_n  = pc_inc + b_off;
                        cnt_n = cnt_inc;
                    end else if (bus.take_branch && opcode == OP_BR) begin
                        pc_n  = {bus.rs_data[15:1], 1'b0};
                        cnt_n = cnt_inc;
                    end else begin
                        pc_n = pc_inc;
                    end
                end
                HALT: ;
                default: state_n = RUN;
            endcase
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus2    = pc_inc;
    assign bus.has_stalled = has_stalled_q;
    assign bus.halted      = halted_q;
    assign bus.taken_cnt   = cnt_q;

    // The decision unit never resolves outside the stall cycle nor re-stalls inside it.
    assert property (@(posedge clk) disable iff (rst)
        (state == RUN && !bus.freeze) |-> !bus.take_branch);
    assert property (@(posedge clk) disable iff (rst)
        (state == BR_WAIT && !bus.freeze) |-> !bus.stall_en);
endmodule

// File: tb/tb_pc_control.sv
// Self-checking bench for pc_control: directed scenarios plus random traffic against a sequencer model.
module tb_pc_control;
    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    // Model of the architectural sequencer state
    int m_pc;
    bit m_wait;
    bit m_halt;
    int m_cnt;

    pc_control_if #(.CNT_W(CNT_W)) bus ();

    pc_control #(.RESET_PC(16'h0000), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int wrap16(input int v);
        return ((v % 65536) + 65536) % 65536;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_wait = 0; m_halt = 0; m_cnt = 0;
    endtask

    task automatic model_update(input logic [15:0] ins, input logic [15:0] rs, input bit tk, input bit fz);
        int op;
        int imm;
        op  = int'(ins[15:12]);
        imm = int'(ins[8:0]);
        if (imm >= 256) imm = imm - 512;
        if (fz || m_halt) return;
        if (m_wait) begin
            m_wait = 0;
            if (tk && op == 12) begin
                m_pc  = wrap16(m_pc + 2 + 2 * imm);
                m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
            end else if (tk && op == 13) begin
                m_pc  = int'(rs) - (int'(rs) % 2);
                m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
            end else begin
                m_pc = wrap16(m_pc + 2);
            end
        end else if (op == 15) begin
            m_halt = 1;
        end else if (op == 12 || op == 13) begin
            m_wait = 1;
        end else begin
            m_pc = wrap16(m_pc + 2);
        end
    endtask

    task automatic check_model();
        chk("pc",          32'(bus.pc),          32'(m_pc));
        chk("pc_plus2",    32'(bus.pc_plus2),    32'(wrap16(m_pc + 2)));
        chk("has_stalled", 32'(bus.has_stalled), 32'(m_wait));
        chk("halted",      32'(bus.halted),      32'(m_halt));
        chk("taken_cnt",   32'(bus.taken_cnt),   32'(m_cnt));
    endtask

    // Acts as the decision unit: stall on B/BR in RUN, resolve only in the stall cycle.
    task automatic step(input logic [15:0] ins, input logic [15:0] rs, input bit tk, input bit fz);
        bit is_br;
        bit tk_eff;
        is_br           = (ins[15:12] == 4'hC) || (ins[15:12] == 4'hD);
        tk_eff          = tk && m_wait;
        bus.instr       = ins;
        bus.rs_data     = rs;
        bus.freeze      = fz;
        bus.stall_en    = !m_wait && !m_halt && is_br;
        bus.take_branch = tk_eff;
        @(posedge clk);
        model_update(ins, rs, tk_eff, fz);
        #1;
        check_model();
    endtask

    task automatic jump_to(input logic [15:0] addr);
        step(16'hD000, 16'h0000, 1'b0, 1'b0);
        step(16'hD000, addr,     1'b1, 1'b0);
    endtask

    initial begin
        logic [15:0] cur;
        logic [3:0]  op;
        int          r;

        bus.instr = 16'h0000; bus.rs_data = 16'h0000; bus.freeze = 1'b0;
        bus.stall_en = 1'b0; bus.take_branch = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model();
        chk("reset_pc", 32'(bus.pc), 32'h0);
        rst = 1'b0;

        // Straight-line ADDs
        step(16'h0123, 16'h0, 1'b0, 1'b0); chk("add_pc1", 32'(bus.pc), 32'h2);
        step(16'h0456, 16'h0, 1'b0, 1'b0); chk("add_pc2", 32'(bus.pc), 32'h4);
        step(16'h0789, 16'h0, 1'b0, 1'b0); chk("add_pc3", 32'(bus.pc), 32'h6);

        // Taken B forward from 0x0010
        jump_to(16'h0011);
        chk("br_to_10", 32'(bus.pc), 32'h10);
        step(16'hCE04, 16'h0, 1'b0, 1'b0);
        chk("b_stall_pc", 32'(bus.pc), 32'h10);
        chk("b_stall_flag", 32'(bus.has_stalled), 32'h1);
        step(16'hCE04, 16'h0, 1'b1, 1'b0);
        chk("b_taken_pc", 32'(bus.pc), 32'h1A);
        chk("b_taken_cnt", 32'(bus.taken_cnt), 32'h2);

        // Negative offset: untaken then taken self-loop
        jump_to(16'h0020);
        step(16'hC1FF, 16'h0, 1'b0, 1'b0);
        step(16'hC1FF, 16'h0, 1'b0, 1'b0);
        chk("b_untaken_pc", 32'(bus.pc), 32'h22);
        jump_to(16'h0020);
        step(16'hC1FF, 16'h0, 1'b0, 1'b0);
        step(16'hC1FF, 16'h0, 1'b1, 1'b0);
        chk("b_selfloop_pc", 32'(bus.pc), 32'h20);

        // BR target LSB cleared; PC wrap
        jump_to(16'h1235);
        chk("br_lsb_pc", 32'(bus.pc), 32'h1234);
        jump_to(16'hFFFF);
        chk("br_top_pc", 32'(bus.pc), 32'hFFFE);
        chk("wrap_plus2", 32'(bus.pc_plus2), 32'h0);
        step(16'h1000, 16'h0, 1'b0, 1'b0);
        chk("wrap_pc", 32'(bus.pc), 32'h0);

        // Freeze during the resolve cycle
        step(16'hC003, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(16'hC003, 16'h0, 1'b1, 1'b1);
            chk("frz_stall", 32'(bus.has_stalled), 32'h1);
            chk("frz_pc", 32'(bus.pc), 32'h0);
        end
        step(16'hC003, 16'h0, 1'b1, 1'b0);
        chk("frz_resolve_pc", 32'(bus.pc), 32'h8);
        chk("frz_resolve_stall", 32'(bus.has_stalled), 32'h0);

        // Random traffic (no HLT); instruction held while its branch resolves
        cur = 16'h0000;
        for (int n = 0; n < 3000; n++) begin
            if (!m_wait) begin
                r = int'($urandom_range(0, 9));
                if (r == 6 || r == 7)   op = 4'hC;
                else if (r == 8)        op = 4'hD;
                else                    op = 4'($urandom_range(0, 11));
                cur = {op, 12'($urandom)};
            end
            step(cur, 16'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0));
        end
        chk("cnt_saturated", 32'(bus.taken_cnt), 32'(CNT_MAX));

        // HLT holds for good
        jump_to(16'h0040);
        step(16'hF000, 16'h0, 1'b0, 1'b0);
        chk("hlt_flag", 32'(bus.halted), 32'h1);
        for (int i = 0; i < 10; i++) begin
            step(16'h0000, 16'h0, 1'b0, 1'b0);
            chk("hlt_pc", 32'(bus.pc), 32'h40);
        end

        // Async reset mid-stall, observed before the next clock edge
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check_model();
        step(16'h0000, 16'h0, 1'b0, 1'b0);
        step(16'hC010, 16'h0, 1'b0, 1'b0);
        chk("pre_rst_stall", 32'(bus.has_stalled), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_pc", 32'(bus.pc), 32'h0);
        chk("async_rst_stall", 32'(bus.has_stalled), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        step(16'h0000, 16'h0, 1'b0, 1'b0);
        chk("post_rst_pc", 32'(bus.pc), 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
